// File: rtl/fill_pkg.sv
// -----------------------------------------------------------------------------
// fill_pkg
//   Shared types for the screen fill sequencer.
//   state_t  : sequencer states (CLEAR sweep after reset, IDLE, FILL sweep, DONE)
//   id_width : width of a channel ID for n request channels (at least 1 bit)
// -----------------------------------------------------------------------------
package fill_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/screen_fill_ctrl_if.sv
// -----------------------------------------------------------------------------
// screen_fill_ctrl_if
//   Pixel write port between the fill sequencer and the frame-buffer writer.
//   wr_valid  master->slave  pixel write request
//   wr_ready  slave->master  pixel accepted when wr_valid && wr_ready
//   wr_x      master->slave  pixel column (XW bits)
//   wr_y      master->slave  pixel row (YW bits)
//   wr_color  master->slave  pixel colour (COLOR_W bits)
// -----------------------------------------------------------------------------
interface screen_fill_ctrl_if #(
    parameter int XW      = 8,
    parameter int YW      = 7,
    parameter int COLOR_W = 12
);
    logic               wr_valid;
    logic               wr_ready;
    logic [XW-1:0]      wr_x;
    logic [YW-1:0]      wr_y;
    logic [COLOR_W-1:0] wr_color;

    modport master (
        output wr_valid, wr_x, wr_y, wr_color,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_color,
        output wr_ready
    );
endinterface

// File: rtl/req_edge_arbiter.sv
// -----------------------------------------------------------------------------
// req_edge_arbiter
//   Rising-edge detector and lowest-index priority encoder for the fill
//   request lines.
//   clk, reset_n : clock, synchronous active-low reset
//   req          : debounced level requests, one per channel
//   hit          : at least one channel rose this cycle
//   hit_id       : lowest channel index that rose (valid when hit)
// -----------------------------------------------------------------------------
module req_edge_arbiter
    import fill_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int RW      = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic               hit,
    output logic [RW-1:0]      hit_id
);

    logic [NUM_REQ-1:0] req_hist_q;
    logic [NUM_REQ-1:0] req_hist_d;
    logic [NUM_REQ-1:0] rise;

    assign req_hist_d = req;

    // Reset loads the live request levels too, so a button held through
    // reset is seen as already high and never produces an edge.
    // NOTE: flops use non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_hist_q <= req;
        end else begin
            req_hist_q <= req_hist_d;
        end
    end

    // Scan from the top down so the lowest set index is the last to write.
    always_comb begin
        rise   = req & ~req_hist_q;
        hit    = |rise;
        hit_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rise[i]) hit_id = RW'(i);
        end
    end

endmodule

// File: rtl/screen_fill_ctrl.sv
// -----------------------------------------------------------------------------
// screen_fill_ctrl
//   Full-screen fill sequencer. Clears the frame to CLEAR_COLOR after reset,
//   then fills the whole frame with palette colour i on a rising edge of
//   req[i]. Pixels are issued in raster order over a valid/ready port.
//   clk, reset_n : clock, synchronous active-low reset
//   req          : debounced level requests, one per colour channel
//   palette      : colour i at [i*COLOR_W +: COLOR_W], sampled when a fill starts
//   wr           : pixel write port (master side)
//   busy         : high while sweeping (CLEAR or FILL)
//   done         : one-cycle pulse after the last pixel of a sweep is accepted
//   active_id    : channel being filled (0 during CLEAR)
// -----------------------------------------------------------------------------
module screen_fill_ctrl
    import fill_pkg::*;
#(
    parameter  int               H_PIX       = 160,
    parameter  int               V_PIX       = 120,
    parameter  int               COLOR_W     = 12,
    parameter  int               NUM_REQ     = 4,
    parameter  logic [COLOR_W-1:0] CLEAR_COLOR = '0,
    localparam int               XW          = $clog2(H_PIX),
    localparam int               YW          = $clog2(V_PIX),
    localparam int               RW          = id_width(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*COLOR_W-1:0] palette,
    screen_fill_ctrl_if.master         wr,
    output logic                       busy,
    output logic                       done,
    output logic [RW-1:0]              active_id
);

    localparam logic [XW-1:0] X_LAST = XW'(H_PIX - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_PIX - 1);

    state_t             state_q, state_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [RW-1:0]      id_q, id_d;
    logic               done_q, done_d;
    logic               pend_v_q, pend_v_d;
    logic [RW-1:0]      pend_id_q, pend_id_d;

    logic               hit;
    logic [RW-1:0]      hit_id;
    logic               sweeping;
    logic               handshake;
    logic               launch;
    logic [RW-1:0]      launch_id;

    req_edge_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .hit     (hit),
        .hit_id  (hit_id)
    );

    assign sweeping  = (state_q == ST_CLEAR) || (state_q == ST_FILL);
    assign handshake = sweeping && wr.wr_ready;

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        color_d   = color_q;
        id_d      = id_q;
        done_d    = 1'b0;
        pend_v_d  = pend_v_q;
        pend_id_d = pend_id_q;
        launch    = 1'b0;
        launch_id = hit_id;

        unique case (state_q)
            ST_CLEAR, ST_FILL: begin
                // Requests arriving mid-sweep park in the single pending slot.
                if (hit) begin
                    pend_v_d  = 1'b1;
                    pend_id_d = hit_id;
                end
                if (handshake) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                // A slot filled during the DONE cycle is launched from here.
                if (hit) begin
                    launch = 1'b1;
                end else if (pend_v_q) begin
                    launch    = 1'b1;
                    launch_id = pend_id_q;
                    pend_v_d  = 1'b0;
                end
            end
            ST_DONE: begin
                if (pend_v_q) begin
                    launch    = 1'b1;
                    launch_id = pend_id_q;
                    pend_v_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
                if (hit) begin
                    pend_v_d  = 1'b1;
                    pend_id_d = hit_id;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                x_d     = '0;
                y_d     = '0;
                color_d = CLEAR_COLOR;
                id_d    = '0;
            end
        endcase

        // Colour is taken from the palette only at the moment a fill starts.
        if (launch) begin
            state_d = ST_FILL;
            id_d    = launch_id;
            color_d = palette[launch_id*COLOR_W +: COLOR_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_CLEAR;
            x_q       <= '0;
            y_q       <= '0;
            color_q   <= CLEAR_COLOR;
            id_q      <= '0;
            done_q    <= 1'b0;
            pend_v_q  <= 1'b0;
            pend_id_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            color_q   <= color_d;
            id_q      <= id_d;
            done_q    <= done_d;
            pend_v_q  <= pend_v_d;
            pend_id_q <= pend_id_d;
        end
    end

    assign wr.wr_valid = sweeping;
    assign wr.wr_x     = x_q;
    assign wr.wr_y     = y_q;
    assign wr.wr_color = color_q;
    assign busy        = sweeping;
    assign done        = done_q;
    assign active_id   = id_q;

endmodule

// File: tb/tb_screen_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_screen_fill_ctrl
//   Directed bench for screen_fill_ctrl on a 4x3 frame with four channels.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_screen_fill_ctrl;

    localparam int              H_PIX   = 4;
    localparam int              V_PIX   = 3;
    localparam int              NPIX    = H_PIX * V_PIX;
    localparam int              COLOR_W = 12;
    localparam int              NUM_REQ = 4;
    localparam logic [11:0]     CLR     = 12'h0A5;
    localparam int              MAXC    = 60;

    localparam logic [11:0] P0 = 12'h0F0;
    localparam logic [11:0] P1 = 12'h00F;
    localparam logic [11:0] P2 = 12'hF00;
    localparam logic [11:0] P3 = 12'h777;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } stim_t;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*COLOR_W-1:0] palette;
    logic                       busy;
    logic                       done;
    logic [1:0]                 active_id;

    int    n_tests = 0;
    int    n_fail  = 0;
    stim_t stim_q[$];

    screen_fill_ctrl_if #(.XW(2), .YW(2), .COLOR_W(COLOR_W)) wr_if ();

    screen_fill_ctrl #(
        .H_PIX       (H_PIX),
        .V_PIX       (V_PIX),
        .COLOR_W     (COLOR_W),
        .NUM_REQ     (NUM_REQ),
        .CLEAR_COLOR (CLR)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .palette   (palette),
        .wr        (wr_if),
        .busy      (busy),
        .done      (done),
        .active_id (active_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Runs one sweep starting at the current falling edge (cycle 0).
    // mode 0 keeps wr_ready high; mode 1 raises it on odd cycles only.
    // Every valid cycle must show the next unaccepted raster pixel, which
    // also proves outputs hold while wr_ready is low.
    task automatic sweep(input string tag, input logic [11:0] col, input int id,
                         input int mode, input int exp_first, input int exp_done,
                         input logic exp_busy_after);
        int n        = 0;
        int first    = -1;
        int done_cyc = -1;
        for (int cyc = 0; cyc < MAXC; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (stim_q.size() > 0 && stim_q[0].cyc == cyc) begin
                req = stim_q[0].val;
                void'(stim_q.pop_front());
            end
            wr_if.wr_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (wr_if.wr_valid) begin
                if (first < 0) begin
                    first = cyc;
                    check({tag, ".id"}, 32'(active_id), 32'(id));
                end
                check({tag, ".x"}, 32'(wr_if.wr_x), 32'(n % H_PIX));
                check({tag, ".y"}, 32'(wr_if.wr_y), 32'(n / H_PIX));
                check({tag, ".color"}, 32'(wr_if.wr_color), 32'(col));
                if (wr_if.wr_ready) n++;
            end
        end
        check({tag, ".first_valid_cycle"}, 32'(first), 32'(exp_first));
        check({tag, ".done_cycle"}, 32'(done_cyc), 32'(exp_done));
        check({tag, ".handshakes"}, 32'(n), 32'(NPIX));
        check({tag, ".valid_in_done"}, 32'(wr_if.wr_valid), 32'd0);
        @(negedge clk);
        wr_if.wr_ready = 1'b1;
        check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
        check({tag, ".busy_after"}, 32'(busy), 32'(exp_busy_after));
    endtask

    task automatic quiet_cycles(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (wr_if.wr_valid || busy) seen++;
        end
        check({tag, ".no_activity"}, 32'(seen), 32'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        req            = '0;
        palette        = {P3, P2, P1, P0};
        wr_if.wr_ready = 1'b1;

        // 1: reset state, then post-reset clear sweep
        repeat (3) @(negedge clk);
        check("rst.x", 32'(wr_if.wr_x), 32'd0);
        check("rst.y", 32'(wr_if.wr_y), 32'd0);
        check("rst.color", 32'(wr_if.wr_color), 32'(CLR));
        check("rst.done", 32'(done), 32'd0);
        check("rst.active_id", 32'(active_id), 32'd0);
        check("rst.busy", 32'(busy), 32'd1);
        reset_n = 1'b1;
        sweep("clear", CLR, 0, 0, 0, 12, 1'b0);

        // 2: fill from IDLE, first valid one cycle after the edge
        req = 4'b0100;
        sweep("fill_ch2", P2, 2, 0, 1, 13, 1'b0);

        // 3: wr_ready toggling 1010..
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0001;
        sweep("stall_ch0", P0, 0, 1, 1, 24, 1'b0);

        // 4: simultaneous edges pick ch1; pending ch3 overwritten by ch0
        req = 4'b0000;
        @(negedge clk);
        req = 4'b1010;
        stim_q.push_back('{2, 4'b0000});
        stim_q.push_back('{4, 4'b1000});
        stim_q.push_back('{6, 4'b1001});
        sweep("prio_ch1", P1, 1, 0, 1, 13, 1'b1);
        sweep("pend_ch0", P0, 0, 0, 0, 12, 1'b0);
        quiet_cycles("ch3_dropped", 5);

        // 5: reset at pixel 5 with a pending request and a held button
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0100;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 3) req = 4'b0101;
        end
        check("midfill.x", 32'(wr_if.wr_x), 32'd1);
        check("midfill.y", 32'(wr_if.wr_y), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort.x", 32'(wr_if.wr_x), 32'd0);
        check("abort.y", 32'(wr_if.wr_y), 32'd0);
        check("abort.color", 32'(wr_if.wr_color), 32'(CLR));
        check("abort.done", 32'(done), 32'd0);
        check("abort.active_id", 32'(active_id), 32'd0);
        reset_n = 1'b1;
        sweep("reclear", CLR, 0, 0, 0, 12, 1'b0);
        quiet_cycles("held_through_reset", 5);

        // 6: a held request fires once; it re-arms only after going low
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0010;
        sweep("held_ch1", P1, 1, 0, 1, 13, 1'b0);
        quiet_cycles("held_no_refire", 85);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0010;
        sweep("retrig_ch1", P1, 1, 0, 1, 13, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
